// File: rtl/uart_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART TX scheduler.
package uart_ctrl_pkg;

  localparam int unsigned DefNreq        = 4;
  localparam int unsigned DefGapCycles   = 2;
  localparam int unsigned DefSendTimeout = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StSend,
    StWaitDone,
    StGap
  } state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Producer/core side bundle of the scheduler; master is the environment (producers and the UART
// core), slave is the scheduler itself.
interface uart_tx_scheduler_if
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq
) ();

  localparam int unsigned IdW = $clog2(NREQ);

  logic [NREQ-1:0]   Req_Valid;
  logic [8*NREQ-1:0] Req_Data;
  logic [NREQ-1:0]   Req_Ready;
  logic [7:0]        Tx_Data;
  logic              Tx_Data_Ready;
  logic              Tx_Data_Send;
  logic              Tx_Busy;
  logic [IdW-1:0]    Grant_Id;
  logic              Active;
  logic              Timeout_Err;

  modport master (
    output Req_Valid, Req_Data, Tx_Busy,
    input  Req_Ready, Tx_Data, Tx_Data_Ready, Tx_Data_Send, Grant_Id, Active, Timeout_Err
  );

  modport slave (
    input  Req_Valid, Req_Data, Tx_Busy,
    output Req_Ready, Tx_Data, Tx_Data_Ready, Tx_Data_Send, Grant_Id, Active, Timeout_Err
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index searching upward from last+1 (mod NREQ).
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IdW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IdW-1:0]  grant_idx,
  output logic            any
);

  logic [NREQ-1:0] rot;

  always_comb begin
    int off;
    int pos;
    // Rotate so that bit 0 of rot is requester last+1.
    rot = NREQ'({valid, valid} >> (int'(last) + 1));
    off = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    pos = int'(last) + 1 + off;
    if (pos >= int'(NREQ)) pos = pos - int'(NREQ);
    any   = |valid;
    grant = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (i == pos) grant[i] = any;
    end
    grant_idx = IdW'(pos);
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX core among NREQ byte producers; sequences the core's
// load / settle / send handshake and waits for each frame to finish before the next grant.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NREQ         = DefNreq,
  parameter int unsigned GAP_CYCLES   = DefGapCycles,
  parameter int unsigned SEND_TIMEOUT = DefSendTimeout
) (
  input logic                Clk,
  input logic                RST,
  uart_tx_scheduler_if.slave bus
);

  localparam int unsigned IdW   = $clog2(NREQ);
  localparam int unsigned SendW = $clog2(SEND_TIMEOUT + 1);
  localparam int unsigned GapW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  // A zero-length gap collapses the frame-end transition straight into IDLE.
  localparam state_e PostFrame = state_e'((GAP_CYCLES == 0) ? StIdle : StGap);

  state_e          state_q, state_d;
  logic [7:0]      data_q;
  logic [IdW-1:0]  last_q;
  logic [IdW-1:0]  grant_q;
  logic [SendW-1:0] send_cnt_q;
  logic [GapW-1:0] gap_cnt_q;

  logic [NREQ-1:0] pick_grant;
  logic [IdW-1:0]  pick_idx;
  logic            pick_any;
  logic [7:0]      pick_byte;
  logic            send_expired;
  logic            gap_done;

  rr_picker #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_picker (
    .valid     (bus.Req_Valid),
    .last      (last_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_grant[i]) pick_byte = bus.Req_Data[8*i +: 8];
    end
  end

  assign send_expired = (send_cnt_q == SendW'(SEND_TIMEOUT));
  assign gap_done     = (gap_cnt_q == GapW'(GAP_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (pick_any) state_d = StLoad;
      StLoad:     state_d = StSettle;
      StSettle:   state_d = StSend;
      StSend: begin
        // Busy takes precedence over a timeout expiring in the same cycle.
        if (bus.Tx_Busy)       state_d = StWaitDone;
        else if (send_expired) state_d = PostFrame;
      end
      StWaitDone: if (!bus.Tx_Busy) state_d = PostFrame;
      StGap:      if (gap_done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      data_q     <= '0;
      last_q     <= IdW'(NREQ - 1);
      grant_q    <= '0;
      send_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      if (state_q == StIdle && pick_any) begin
        data_q  <= pick_byte;
        last_q  <= pick_idx;
        grant_q <= pick_idx;
      end
      send_cnt_q <= (state_q == StSend) ? send_cnt_q + 1'b1 : '0;
      gap_cnt_q  <= (state_q == StGap) ? gap_cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    bus.Req_Ready     = '0;
    bus.Tx_Data_Ready = 1'b0;
    bus.Tx_Data_Send  = 1'b0;
    bus.Timeout_Err   = 1'b0;
    unique case (state_q)
      // No handshake while reset is held: the accept would be discarded.
      StIdle: if (!RST) bus.Req_Ready = pick_grant;
      StLoad: bus.Tx_Data_Ready = 1'b1;
      StSend: begin
        bus.Tx_Data_Send = !send_expired;
        bus.Timeout_Err  = send_expired && !bus.Tx_Busy;
      end
      default: ;
    endcase
  end

  assign bus.Tx_Data  = data_q;
  assign bus.Grant_Id = grant_q;
  assign bus.Active   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a default build (gap 2, timeout 64) with a simple core
// model, plus a GAP_CYCLES = 0 build driven by hand.
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NREQ(4)) bus ();
  uart_tx_scheduler_if #(.NREQ(4)) bus0 ();

  uart_tx_scheduler #(.NREQ(4), .GAP_CYCLES(2), .SEND_TIMEOUT(64)) dut (
    .Clk (clk),
    .RST (rst),
    .bus (bus)
  );

  uart_tx_scheduler #(.NREQ(4), .GAP_CYCLES(0), .SEND_TIMEOUT(64)) dut0 (
    .Clk (clk),
    .RST (rst),
    .bus (bus0)
  );

  int checks = 0;
  int errors = 0;

  // Core model: raises busy on the first negedge it sees Tx_Data_Send, holds it busy_len cycles.
  bit core_on   = 1'b0;
  int busy_len  = 12;
  int busy_left = 0;
  bit model_busy = 1'b0;
  bit man_mode  = 1'b0;
  bit man_busy  = 1'b0;

  always @(negedge clk) begin
    if (!core_on) begin
      busy_left  = 0;
      model_busy = 1'b0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) model_busy = 1'b0;
    end else if (bus.Tx_Data_Send && !model_busy) begin
      model_busy = 1'b1;
      busy_left  = busy_len;
    end
  end

  assign bus.Tx_Busy = man_mode ? man_busy : model_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Req_Valid  = '0;
    bus.Req_Data   = '0;
    bus0.Req_Valid = '0;
    bus0.Req_Data  = '0;
    bus0.Tx_Busy   = 1'b0;
    core_on  = 1'b0;
    man_mode = 1'b0;
    man_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.Active === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.Req_Ready !== 4'b0 || bus.Tx_Data_Ready !== 1'b0 || bus.Tx_Data_Send !== 1'b0
        || bus.Timeout_Err !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got rdy=%b ld=%b snd=%b terr=%b want 0", bus.Req_Ready,
               bus.Tx_Data_Ready, bus.Tx_Data_Send, bus.Timeout_Err);
    end
    checks++;
    if (bus.Tx_Data !== 8'h00 || bus.Grant_Id !== 2'd0 || bus.Active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h gid=%0d act=%b want 0", bus.Tx_Data, bus.Grant_Id,
               bus.Active);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    bus.Req_Data  = 32'h0000_00A5;
    bus.Req_Valid = 4'b0001;
    busy_len = 12;
    core_on  = 1'b1;
    #1;
    checks++;
    if (bus.Req_Ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b want 0001", bus.Req_Ready);
    end
    tick();
    bus.Req_Valid = '0;
    checks++;
    if (bus.Tx_Data_Ready !== 1'b1 || bus.Tx_Data !== 8'hA5 || bus.Tx_Data_Send !== 1'b0) begin
      errors++;
      $display("FAIL single_load: got ld=%b data=%h snd=%b want 1 a5 0", bus.Tx_Data_Ready,
               bus.Tx_Data, bus.Tx_Data_Send);
    end
    tick();
    checks++;
    if (bus.Tx_Data_Ready !== 1'b0 || bus.Tx_Data_Send !== 1'b0) begin
      errors++;
      $display("FAIL single_settle: got ld=%b snd=%b want 0 0", bus.Tx_Data_Ready,
               bus.Tx_Data_Send);
    end
    tick();
    checks++;
    if (bus.Tx_Data_Send !== 1'b1 || bus.Tx_Data_Ready !== 1'b0) begin
      errors++;
      $display("FAIL single_send: got snd=%b ld=%b want 1 0", bus.Tx_Data_Send, bus.Tx_Data_Ready);
    end
    wait_idle(n);
    checks++;
    if (n != 15) begin
      errors++; $display("FAIL single_active_drop: got %0d cycles want 15", n);
    end
    checks++;
    if (bus.Tx_Data !== 8'hA5 || bus.Grant_Id !== 2'd0) begin
      errors++;
      $display("FAIL single_hold: got data=%h gid=%0d want a5 0", bus.Tx_Data, bus.Grant_Id);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int e;
    logic [3:0] exp_rdy;
    logic [7:0] exp_data;
    do_reset();
    busy_len = 3;
    core_on  = 1'b1;
    bus.Req_Data  = 32'h4433_2211;
    bus.Req_Valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      exp_rdy  = 4'(1 << e);
      exp_data = 8'(8'h11 * (e + 1));
      #1;
      checks++;
      if (bus.Req_Ready !== exp_rdy) begin
        errors++; $display("FAIL rr_ready_%0d: got %b want %b", k, bus.Req_Ready, exp_rdy);
      end
      tick();
      checks++;
      if (bus.Grant_Id !== 2'(e) || bus.Tx_Data !== exp_data) begin
        errors++;
        $display("FAIL rr_grant_%0d: got gid=%0d data=%h want %0d %h", k, bus.Grant_Id,
                 bus.Tx_Data, e, exp_data);
      end
      wait_idle(n);
      checks++;
      if (n < 0) begin
        errors++; $display("FAIL rr_frame_end_%0d: got timeout want idle", k);
      end
    end
    bus.Req_Valid = '0;
  endtask

  task automatic test_skip();
    int n;
    do_reset();
    busy_len = 3;
    core_on  = 1'b1;
    bus.Req_Data  = 32'hD3C2_B1A0;
    bus.Req_Valid = 4'b1010;
    #1;
    checks++;
    if (bus.Req_Ready !== 4'b0010) begin
      errors++; $display("FAIL skip_first: got %b want 0010", bus.Req_Ready);
    end
    tick();
    checks++;
    if (bus.Grant_Id !== 2'd1 || bus.Tx_Data !== 8'hB1) begin
      errors++;
      $display("FAIL skip_grant1: got gid=%0d data=%h want 1 b1", bus.Grant_Id, bus.Tx_Data);
    end
    wait_idle(n);
    checks++;
    if (n != 8 || bus.Req_Ready !== 4'b1000) begin
      errors++;
      $display("FAIL skip_to_3: got cycles=%0d rdy=%b want 8 1000", n, bus.Req_Ready);
    end
    tick();
    checks++;
    if (bus.Grant_Id !== 2'd3 || bus.Tx_Data !== 8'hD3) begin
      errors++;
      $display("FAIL skip_grant3: got gid=%0d data=%h want 3 d3", bus.Grant_Id, bus.Tx_Data);
    end
    bus.Req_Valid = '0;
    wait_idle(n);
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.Req_Data  = 32'h0000_5A3C;
    bus.Req_Valid = 4'b0001;
    #1;
    tick();
    bus.Req_Valid = '0;
    tick();
    tick();
    checks++;
    if (bus.Tx_Data_Send !== 1'b1) begin
      errors++; $display("FAIL to_send_rise: got %b want 1", bus.Tx_Data_Send);
    end
    n = 0;
    while (bus.Timeout_Err !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++; $display("FAIL to_latency: got %0d cycles want 64", n);
    end
    checks++;
    if (bus.Tx_Data_Send !== 1'b0) begin
      errors++; $display("FAIL to_send_drop: got %b want 0", bus.Tx_Data_Send);
    end
    tick();
    checks++;
    if (bus.Timeout_Err !== 1'b0) begin
      errors++; $display("FAIL to_single_pulse: got %b want 0", bus.Timeout_Err);
    end
    bus.Req_Valid = 4'b0011;
    busy_len = 3;
    core_on  = 1'b1;
    n = 0;
    while (bus.Req_Ready === 4'b0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2 || bus.Req_Ready !== 4'b0010) begin
      errors++;
      $display("FAIL to_next_req: got cycles=%0d rdy=%b want 2 0010", n, bus.Req_Ready);
    end
    tick();
    bus.Req_Valid = '0;
    checks++;
    if (bus.Grant_Id !== 2'd1 || bus.Tx_Data !== 8'h5A) begin
      errors++;
      $display("FAIL to_next_grant: got gid=%0d data=%h want 1 5a", bus.Grant_Id, bus.Tx_Data);
    end
    wait_idle(n);
  endtask

  task automatic test_busy_wins();
    int n;
    do_reset();
    bus.Req_Data  = 32'h0000_0077;
    bus.Req_Valid = 4'b0001;
    #1;
    tick();
    bus.Req_Valid = '0;
    tick();
    tick();
    repeat (63) tick();
    checks++;
    if (bus.Tx_Data_Send !== 1'b1) begin
      errors++; $display("FAIL bw_send_hold: got %b want 1", bus.Tx_Data_Send);
    end
    tick();
    man_mode = 1'b1;
    man_busy = 1'b1;
    #1;
    checks++;
    if (bus.Timeout_Err !== 1'b0) begin
      errors++; $display("FAIL bw_no_err: got %b want 0", bus.Timeout_Err);
    end
    tick();
    checks++;
    if (bus.Tx_Data_Send !== 1'b0 || bus.Timeout_Err !== 1'b0) begin
      errors++;
      $display("FAIL bw_wait_enter: got snd=%b terr=%b want 0 0", bus.Tx_Data_Send,
               bus.Timeout_Err);
    end
    repeat (3) tick();
    checks++;
    if (bus.Active !== 1'b1) begin
      errors++; $display("FAIL bw_still_waiting: got act=%b want 1", bus.Active);
    end
    man_busy = 1'b0;
    wait_idle(n);
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL bw_frame_end: got %0d cycles want 3", n);
    end
    man_mode = 1'b0;
  endtask

  task automatic test_reset_wait();
    int n;
    do_reset();
    busy_len = 20;
    core_on  = 1'b1;
    bus.Req_Data  = 32'h0099_0055;
    bus.Req_Valid = 4'b0100;
    #1;
    tick();
    bus.Req_Valid = '0;
    repeat (3) tick();
    checks++;
    if (bus.Active !== 1'b1 || bus.Tx_Data_Send !== 1'b0 || bus.Grant_Id !== 2'd2
        || bus.Tx_Data !== 8'h99) begin
      errors++;
      $display("FAIL rw_in_wait: got act=%b snd=%b gid=%0d data=%h want 1 0 2 99", bus.Active,
               bus.Tx_Data_Send, bus.Grant_Id, bus.Tx_Data);
    end
    rst = 1'b1;
    core_on = 1'b0;
    tick();
    checks++;
    if (bus.Active !== 1'b0 || bus.Tx_Data !== 8'h00 || bus.Grant_Id !== 2'd0
        || bus.Req_Ready !== 4'b0 || bus.Tx_Data_Ready !== 1'b0 || bus.Tx_Data_Send !== 1'b0
        || bus.Timeout_Err !== 1'b0) begin
      errors++;
      $display("FAIL rw_cleared: got act=%b data=%h gid=%0d rdy=%b ld=%b snd=%b terr=%b want 0",
               bus.Active, bus.Tx_Data, bus.Grant_Id, bus.Req_Ready, bus.Tx_Data_Ready,
               bus.Tx_Data_Send, bus.Timeout_Err);
    end
    bus.Req_Valid = 4'b0101;
    #1;
    checks++;
    if (bus.Req_Ready !== 4'b0) begin
      errors++; $display("FAIL rw_ready_in_reset: got %b want 0000", bus.Req_Ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.Req_Ready !== 4'b0001) begin
      errors++; $display("FAIL rw_first_grant: got %b want 0001", bus.Req_Ready);
    end
    tick();
    bus.Req_Valid = '0;
    core_on = 1'b1;
    checks++;
    if (bus.Grant_Id !== 2'd0 || bus.Tx_Data !== 8'h55) begin
      errors++;
      $display("FAIL rw_grant0: got gid=%0d data=%h want 0 55", bus.Grant_Id, bus.Tx_Data);
    end
    wait_idle(n);
  endtask

  task automatic test_gap0();
    do_reset();
    bus0.Req_Data  = 32'h0000_EE81;
    bus0.Req_Valid = 4'b0001;
    #1;
    checks++;
    if (bus0.Req_Ready !== 4'b0001) begin
      errors++; $display("FAIL g0_ready: got %b want 0001", bus0.Req_Ready);
    end
    tick();
    bus0.Req_Valid = '0;
    tick();
    tick();
    checks++;
    if (bus0.Tx_Data_Send !== 1'b1) begin
      errors++; $display("FAIL g0_send: got %b want 1", bus0.Tx_Data_Send);
    end
    bus0.Tx_Busy = 1'b1;
    repeat (4) tick();
    bus0.Tx_Busy   = 1'b0;
    bus0.Req_Valid = 4'b0010;
    #1;
    checks++;
    if (bus0.Req_Ready !== 4'b0 || bus0.Active !== 1'b1) begin
      errors++;
      $display("FAIL g0_not_yet: got rdy=%b act=%b want 0000 1", bus0.Req_Ready, bus0.Active);
    end
    tick();
    checks++;
    if (bus0.Req_Ready !== 4'b0010 || bus0.Active !== 1'b0) begin
      errors++;
      $display("FAIL g0_ready_next: got rdy=%b act=%b want 0010 0", bus0.Req_Ready, bus0.Active);
    end
    tick();
    bus0.Req_Valid = '0;
    checks++;
    if (bus0.Grant_Id !== 2'd1 || bus0.Tx_Data !== 8'hEE) begin
      errors++;
      $display("FAIL g0_grant1: got gid=%0d data=%h want 1 ee", bus0.Grant_Id, bus0.Tx_Data);
    end
    tick();
    tick();
    bus0.Tx_Busy = 1'b1;
    tick();
    bus0.Tx_Busy = 1'b0;
    tick();
    checks++;
    if (bus0.Active !== 1'b0) begin
      errors++; $display("FAIL g0_second_end: got act=%b want 0", bus0.Active);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_timeout();
    test_busy_wins();
    test_reset_wait();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
